// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART divisor constants, rate encodings and timer state type
package uart_pkg;

  // Clocks per bit at a 50 MHz system clock
  localparam int unsigned UART_DIV_9600   = 5208;
  localparam int unsigned UART_DIV_115200 = 434;
  localparam int unsigned UART_DIV_230400 = 217;
  localparam int unsigned UART_DIV_1M8    = 27;

  localparam logic [1:0] RATE_9600   = 2'd0;
  localparam logic [1:0] RATE_115200 = 2'd1;
  localparam logic [1:0] RATE_230400 = 2'd2;
  localparam logic [1:0] RATE_1M8    = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - UART bit-period timer with bit/mid-bit strobes and frame framing
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CNT_W  = 13,
  parameter int unsigned BITS_W = 4,
  parameter int unsigned DIV0   = UART_DIV_9600,
  parameter int unsigned DIV1   = UART_DIV_115200,
  parameter int unsigned DIV2   = UART_DIV_230400,
  parameter int unsigned DIV3   = UART_DIV_1M8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        rate_sel,
  input  logic [BITS_W-1:0] frame_bits,
  output logic              busy,
  output logic              bit_tick,
  output logic              mid_tick,
  output logic [BITS_W-1:0] bit_idx,
  output logic              frame_done
);

  localparam longint unsigned DIV_MAX = (64'd1 << CNT_W) - 64'd1;

  if (DIV0 < 2 || DIV1 < 2 || DIV2 < 2 || DIV3 < 2) begin : g_div_min
    $error("uart_bit_timer: every divisor must be at least 2");
  end
  if (DIV0 > DIV_MAX || DIV1 > DIV_MAX || DIV2 > DIV_MAX || DIV3 > DIV_MAX) begin : g_div_fit
    $error("uart_bit_timer: a divisor does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0]  D0      = CNT_W'(DIV0);
  localparam logic [CNT_W-1:0]  D1      = CNT_W'(DIV1);
  localparam logic [CNT_W-1:0]  D2      = CNT_W'(DIV2);
  localparam logic [CNT_W-1:0]  D3      = CNT_W'(DIV3);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [BITS_W-1:0] LEN_ONE = BITS_W'(1);

  timer_state_t      state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  div_q, div_nxt;
  logic [BITS_W-1:0] len_q, len_nxt;
  logic [BITS_W-1:0] idx_nxt;
  logic [CNT_W-1:0]  div_sel;
  logic              run;
  logic              last_bit;
  logic              launch;

  always_comb begin
    case (rate_sel)
      RATE_9600:   div_sel = D0;
      RATE_115200: div_sel = D1;
      RATE_230400: div_sel = D2;
      default:     div_sel = D3;
    endcase
  end

  // All strobes decode from registered state so they are glitch-free one-cycle pulses
  assign run        = (state == ST_RUN);
  assign busy       = run;
  assign bit_tick   = run && (cnt == div_q - CNT_ONE);
  assign mid_tick   = run && (cnt == (div_q >> 1));
  assign last_bit   = (bit_idx == len_q - LEN_ONE);
  assign frame_done = bit_tick && last_bit;
  assign launch     = start && (frame_bits != '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = div_q;
    len_nxt   = len_q;
    idx_nxt   = bit_idx;
    if (abort) begin
      // abort also swallows a coincident start
      if (run) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    end else if (launch) begin
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      div_nxt   = div_sel;
      len_nxt   = frame_bits;
    end else if (run) begin
      if (bit_tick) begin
        cnt_nxt = '0;
        if (last_bit) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = bit_idx + LEN_ONE;
        end
      end else begin
        cnt_nxt = cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      div_q   <= D0;
      len_q   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div_q   <= div_nxt;
      len_q   <= len_nxt;
      bit_idx <= idx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_bit_timer.sv
// tb/tb_uart_bit_timer.sv - scoreboard bench for uart_bit_timer with a frame-level timing model
module tb_uart_bit_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic [3:0] frame_bits = 4'd0;
  logic       busy, bit_tick, mid_tick, frame_done;
  logic [3:0] bit_idx;

  uart_bit_timer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rate_sel(rate_sel), .frame_bits(frame_bits),
    .busy(busy), .bit_tick(bit_tick), .mid_tick(mid_tick),
    .bit_idx(bit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int div_tab [4] = '{5208, 434, 217, 27};

  // Expected strobe, keyed by the cycle count seen at the negedge where it is visible
  typedef struct {
    longint obs;
    bit     is_bit;
    bit     done;
    int     idx;
  } ev_t;
  ev_t ev_q[$];

  typedef struct {
    longint beg;
    longint fin;
    int     d;
  } frame_t;
  frame_t cur  = '{0, 0, 1};
  frame_t prev = '{0, 0, 1};

  function automatic void exp_state(input longint c, output bit b, output int idx);
    frame_t f;
    f   = (c >= cur.beg) ? cur : prev;
    b   = (c >= f.beg) && (c < f.fin);
    idx = b ? int'((c - f.beg) / f.d) : 0;
  endfunction

  task automatic trim(input longint k);
    ev_t ev;
    while (ev_q.size() > 0 && ev_q[ev_q.size()-1].obs >= k) ev = ev_q.pop_back();
  endtask

  task automatic model_launch(input int rs, input int fb);
    longint k;
    int d;
    k = cyc + 1;
    if (fb == 0) return;
    d = div_tab[rs];
    trim(k);
    prev = cur;
    cur  = '{k, k + longint'(fb) * d, d};
    for (int b = 0; b < fb; b++) begin
      ev_q.push_back('{k + longint'(b) * d + d / 2, 1'b0, 1'b0, b});
      ev_q.push_back('{k + longint'(b + 1) * d - 1, 1'b1, (b == fb - 1), b});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input int rs, input int fb);
    rate_sel   = 2'(rs);
    frame_bits = 4'(fb);
    start      = 1'b1;
    model_launch(rs, fb);
    step();
    start = 1'b0;
  endtask

  task automatic issue_abort(input bit with_start);
    longint k;
    k          = cyc + 1;
    abort      = 1'b1;
    start      = with_start;
    frame_bits = 4'd10;
    trim(k);
    if (cur.fin > k) cur.fin = k;
    step();
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_until(input longint c);
    while (cyc < c) step();
  endtask

  task automatic wait_done();
    wait_until(cur.fin + 2);
  endtask

  task automatic async_reset();
    step();
    #2;
    rst = 1'b0;
    ev_q.delete();
    cur  = '{0, 0, 1};
    prev = cur;
    #1;
    n_tests++;
    if ({busy, bit_tick, mid_tick, frame_done, bit_idx} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: outputs busy/bit/mid/done/idx=%b required 00000000",
               {busy, bit_tick, mid_tick, frame_done, bit_idx});
    end
    step();
    step();
    rst = 1'b1;
  endtask

  // Monitor: pops expected strobes and compares whenever either side shows activity
  always @(negedge clk) begin
    bit   e_mid, e_bit, e_done, e_busy;
    int   e_idx, e_bidx;
    ev_t  ev;
    e_mid = 1'b0; e_bit = 1'b0; e_done = 1'b0; e_idx = 0;
    while (ev_q.size() > 0 && ev_q[0].obs <= cyc) begin
      ev = ev_q.pop_front();
      if (ev.obs < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missed_event: at cyc %0d, strobe was required at cyc %0d", cyc, ev.obs);
      end else if (ev.is_bit) begin
        e_bit = 1'b1; e_done = ev.done; e_idx = ev.idx;
      end else begin
        e_mid = 1'b1;
      end
    end
    if (mid_tick || bit_tick || frame_done || e_mid || e_bit) begin
      n_tests++;
      if ({mid_tick, bit_tick, frame_done} !== {e_mid, e_bit, e_done} ||
          (e_bit && int'(bit_idx) != e_idx)) begin
        n_fail++;
        $display("FAIL strobes @cyc %0d: mid/bit/done=%b idx=%0d required %b idx=%0d",
                 cyc, {mid_tick, bit_tick, frame_done}, bit_idx, {e_mid, e_bit, e_done}, e_idx);
      end
    end
    exp_state(cyc, e_busy, e_bidx);
    n_tests++;
    if (busy !== e_busy || int'(bit_idx) != e_bidx) begin
      n_fail++;
      $display("FAIL busy_idx @cyc %0d: busy=%b idx=%0d required busy=%b idx=%0d",
               cyc, busy, bit_idx, e_busy, e_bidx);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rs, fb, mode;
    longint span;
    repeat (3) step();
    rst = 1'b1;
    step();

    issue_start(1, 0);
    repeat (6) step();

    issue_start(1, 10);
    wait_done();

    issue_start(3, 11);
    wait_until(cur.beg + 100);
    rate_sel   = 2'd0;
    frame_bits = 4'd2;
    wait_done();

    issue_start(2, 10);
    wait_until(cur.beg + 3 * 217 + 40);
    issue_start(2, 1);
    wait_done();

    issue_start(2, 10);
    wait_until(cur.beg + 5 * 217 + 30);
    issue_abort(1'b1);
    repeat (300) step();

    issue_start(3, 10);
    wait_until(cur.fin - 1);
    issue_start(3, 10);
    wait_done();

    issue_start(3, 10);
    repeat (100) step();
    async_reset();
    repeat (20) step();

    issue_start(0, 1);
    wait_done();

    for (int it = 0; it < 25; it++) begin
      rs = ($urandom_range(0, 3) == 0) ? 2 : 3;
      fb = $urandom_range(0, 15);
      issue_start(rs, fb);
      mode = $urandom_range(0, 3);
      span = cur.fin - cyc;
      if (mode == 1 && span > 2) begin
        repeat ($urandom_range(1, int'(span) - 1)) step();
        issue_start($urandom_range(2, 3) == 2 ? 2 : 3, $urandom_range(0, 15));
      end else if (mode == 2 && span > 2) begin
        repeat ($urandom_range(1, int'(span) - 1)) step();
        issue_abort(1'($urandom_range(0, 1)));
      end else if (mode == 3 && span > 1) begin
        wait_until(cur.fin - 1);
        issue_start(3, $urandom_range(1, 15));
      end
      wait_done();
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (5) step();
    n_tests++;
    if (ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_events: %0d strobes never seen, required 0", ev_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bit_timer.md
# uart_bit_timer

Parametrised UART bit-period timer: generates per-bit and mid-bit strobes for a frame of programmable length at one of four run-time-selectable baud divisors. It sits between the UART TX/RX shift FSMs and the system clock, replacing the fixed two-rate delay counter. A frame is launched by a one-cycle `start` and ends with a `frame_done` strobe.

## Interface
- `CNT_W`, 13: divisor counter width; every `DIVn` must fit, i.e. be at most 2^CNT_W − 1.
- `BITS_W`, 4: width of `frame_bits` and `bit_idx`.
- `DIV0`, 5208: clocks per bit for `rate_sel`=0 (9600 Bd at 50 MHz).
- `DIV1`, 434: `rate_sel`=1 (115200 Bd).
- `DIV2`, 217: `rate_sel`=2 (230400 Bd).
- `DIV3`, 27: `rate_sel`=3 (~1.85 MBd).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle frame launch/restart.
- `abort` in 1: terminate the frame immediately.
- `rate_sel` in 2: divisor select; latched at start.
- `frame_bits` in BITS_W: bits per frame (e.g. 10 or 11); latched at start.
- `busy` out 1: frame in progress.
- `bit_tick` out 1: one-cycle strobe at the end of each bit period.
- `mid_tick` out 1: one-cycle strobe at the middle of each bit (RX sampling).
- `bit_idx` out BITS_W: index of the current bit, 0..frame_bits−1.
- `frame_done` out 1: one-cycle strobe coinciding with the last `bit_tick`.

## Operation
- States: IDLE and RUN.
- Internal registers:
  - `cnt` (CNT_W): position within the current bit.
  - `div_q`: latched divisor.
  - `len_q`: latched frame length.
  - `bit_idx`.
- IDLE → RUN when `start`=1 and `frame_bits`≠0. This edge loads `cnt`=0, `bit_idx`=0, `div_q`=DIV[`rate_sel`], `len_q`=`frame_bits`.
- `start` with `frame_bits`=0 is ignored; the block stays IDLE.
- Counting in RUN:
  - `cnt` increments each cycle.
  - When `cnt`=`div_q`−1, `cnt` wraps to 0 and `bit_idx` increments.
  - At the wrap with `bit_idx`=`len_q`−1, the block returns to IDLE and `bit_idx` returns to 0.
- Strobe decode, all from registered state:
  - `bit_tick` = RUN && `cnt`=`div_q`−1.
  - `mid_tick` = RUN && `cnt`=`div_q`>>1 (floor).
  - `frame_done` = `bit_tick` && `bit_idx`=`len_q`−1.
- `busy` = (state=RUN).
- `start` while in RUN restarts the frame: same load as from IDLE, with new `rate_sel` and `frame_bits`. The in-flight `bit_tick` and `frame_done` of that cycle are still emitted.
- `abort` has priority over `start`. In RUN it forces IDLE with `cnt`=0 and `bit_idx`=0 on the next edge; no `frame_done` is emitted after the abort edge. In IDLE it has no effect.
- Changes to `rate_sel` or `frame_bits` during RUN have no effect.
- Divisors below 2 are illegal; this is enforced by an elaboration-time check on `DIV0..DIV3`.

## Timing
- Reset (`rst`=0), asynchronous: state=IDLE, `cnt`=0, `bit_idx`=0, `div_q`=DIV0, `len_q`=0. All outputs read 0 while `rst` is low and after release.
- Let `start` be sampled at edge k with divisor D and length N:
  - `busy` is high from after edge k.
  - `mid_tick` of bit b is high in the cycle ending at edge k+b·D+floor(D/2)+1.
  - `bit_tick` of bit b is high in the cycle ending at edge k+(b+1)·D, for b = 0..N−1.
  - `frame_done` is high with the b=N−1 `bit_tick`.
  - `busy` drops after edge k+N·D.
- Total frame length is exactly N·D cycles; there is no idle gap between consecutive bits.
- Back-to-back frames: a `start` in the `frame_done` cycle begins the new frame with no idle cycle. `busy` stays high throughout.
- Strobe spacing: each strobe is at most one cycle wide. Successive `bit_tick`s are exactly D cycles apart.
- `bit_idx` changes on the edge ending each `bit_tick`.

## Structure
- Shared package `uart_pkg`:
  - default divisor constants (`UART_DIV_9600`, `UART_DIV_115200`, `UART_DIV_230400`, `UART_DIV_1M8`);
  - `rate_sel` encoding constants;
  - state enum (IDLE/RUN).
- Single module; no sub-module is warranted. The divisor mux, counter and bit counter are all local.

## Test plan
- **Reset:** assert `rst`=0 mid-frame at an arbitrary cycle → all outputs 0 immediately (asynchronously). After release, `busy`=0 until the next `start`.
- **Nominal frame:** `rate_sel`=1, `frame_bits`=10, `start` pulse → exactly 10 `bit_tick`s spaced 434 cycles apart, the first 434 cycles after start; `mid_tick` at offset 218 within each bit; `frame_done` on the 10th tick; `busy` high for 4340 cycles.
- **Rate and length latching:** `rate_sel`=3, `frame_bits`=11, start, then change `rate_sel` to 0 mid-frame → 11 bits at 27 cycles each (297 cycles total), unaffected by the change.
- **Restart:** start at `rate_sel`=2, re-`start` at bit 3 with `frame_bits`=1 → tick count restarts, one `bit_tick` 217 cycles later with `frame_done`, then IDLE.
- **Abort:** abort at bit 5 of a 10-bit frame, with `start` asserted in the same cycle → IDLE next cycle, no further ticks, no `frame_done`.
- **Edge cases:** `start` with `frame_bits`=0 → ignored, `busy` stays 0. Back-to-back `start` in the `frame_done` cycle → `busy` continuous; 20 ticks across two 10-bit frames at uniform spacing.
